// File: rtl/dnn2ami_req_arbiter.sv
// Round-robin arbiter with a bounded burst lock that shares one AMI request port between the RD and WR paths.
// Define DNN2AMI_ARB_STATS_EN to add saturating grant/stall statistics counters.
`ifndef AMI_REQUEST_BUS_WIDTH
`define AMI_REQUEST_BUS_WIDTH 64
`endif

module dnn2ami_req_arbiter #(
  parameter  int REQ_W     = `AMI_REQUEST_BUS_WIDTH,
  parameter  int MAX_BURST = 8,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_reqValid,
  input  logic [REQ_W-1:0] rd_reqOut,
  output logic             rd_reqOut_grant,
  input  logic             wr_reqValid,
  input  logic [REQ_W-1:0] wr_reqOut,
  output logic             wr_reqOut_grant,
  output logic             mem_req_valid,
  output logic [REQ_W-1:0] mem_req,
  input  logic             mem_req_ready
`ifdef DNN2AMI_ARB_STATS_EN
  ,
  output logic [31:0]      stat_rd_grants,
  output logic [31:0]      stat_wr_grants,
  output logic [31:0]      stat_stall_cycles
`endif
);

  typedef enum logic {SRC_RD = 1'b0, SRC_WR = 1'b1} src_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic             valid_q, valid_d;
  logic [REQ_W-1:0] req_q, req_d;
  src_e             last_q, last_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             slot_free, gnt_rd, gnt_wr;
  src_e             win;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    slot_free = !valid_q || mem_req_ready;
    gnt_rd    = 1'b0;
    gnt_wr    = 1'b0;
    win       = last_q;
    valid_d   = valid_q;
    req_d     = req_q;
    last_d    = last_q;
    burst_d   = burst_q;

    if (!rst && slot_free) begin
      if (rd_reqValid && wr_reqValid) begin
        // A zero count means no burst is in progress (post-reset), so plain round-robin applies.
        if (burst_q != '0 && burst_q < MAX_CNT) win = last_q;
        else                                    win = (last_q == SRC_RD) ? SRC_WR : SRC_RD;
        gnt_rd = (win == SRC_RD);
        gnt_wr = (win == SRC_WR);
      end else begin
        gnt_rd = rd_reqValid;
        gnt_wr = wr_reqValid;
        win    = wr_reqValid ? SRC_WR : SRC_RD;
      end
    end

    if (gnt_rd || gnt_wr) begin
      req_d   = gnt_wr ? wr_reqOut : rd_reqOut;
      valid_d = 1'b1;
      last_d  = win;
      if (win == last_q) burst_d = (burst_q == MAX_CNT) ? burst_q : burst_q + 1'b1;
      else               burst_d = CNT_W'(1);
    end else if (valid_q && mem_req_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      last_q  <= SRC_WR;
      burst_q <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign rd_reqOut_grant = gnt_rd;
  assign wr_reqOut_grant = gnt_wr;
  assign mem_req_valid   = valid_q;
  assign mem_req         = req_q;

`ifdef DNN2AMI_ARB_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (gnt_rd && stat_rd_q != '1) stat_rd_q <= stat_rd_q + 32'd1;
      if (gnt_wr && stat_wr_q != '1) stat_wr_q <= stat_wr_q + 32'd1;
      if (valid_q && !mem_req_ready && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_rd_grants    = stat_rd_q;
  assign stat_wr_grants    = stat_wr_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_dnn2ami_req_arbiter.sv
// Self-checking bench for dnn2ami_req_arbiter: directed vector table, burst/alternation sequence, and
// randomized traffic against a behavioural model, on MAX_BURST=8 and MAX_BURST=1 instances.
module tb_dnn2ami_req_arbiter;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst, rv, wv, rdy;
  logic [W-1:0] rbus, wbus;
  logic         rg8, wg8, mv8, rg1, wg1, mv1;
  logic [W-1:0] mreq8, mreq1;
`ifdef DNN2AMI_ARB_STATS_EN
  logic [31:0]  s_rd8, s_wr8, s_st8, s_rd1, s_wr1, s_st1;
`endif

  always #5 clk = ~clk;

  dnn2ami_req_arbiter #(.REQ_W(W), .MAX_BURST(8)) dut8 (
    .clk(clk), .rst(rst),
    .rd_reqValid(rv), .rd_reqOut(rbus), .rd_reqOut_grant(rg8),
    .wr_reqValid(wv), .wr_reqOut(wbus), .wr_reqOut_grant(wg8),
    .mem_req_valid(mv8), .mem_req(mreq8), .mem_req_ready(rdy)
`ifdef DNN2AMI_ARB_STATS_EN
    , .stat_rd_grants(s_rd8), .stat_wr_grants(s_wr8), .stat_stall_cycles(s_st8)
`endif
  );

  dnn2ami_req_arbiter #(.REQ_W(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst),
    .rd_reqValid(rv), .rd_reqOut(rbus), .rd_reqOut_grant(rg1),
    .wr_reqValid(wv), .wr_reqOut(wbus), .wr_reqOut_grant(wg1),
    .mem_req_valid(mv1), .mem_req(mreq1), .mem_req_ready(rdy)
`ifdef DNN2AMI_ARB_STATS_EN
    , .stat_rd_grants(s_rd1), .stat_wr_grants(s_wr1), .stat_stall_cycles(s_st1)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how long their current streak is, what sits in the slot.
  typedef struct {
    bit           valid;
    logic [W-1:0] data;
    bit           last_wr;
    int           streak;
    longint       n_rd, n_wr, n_stall;
  } model_t;

  model_t m8, m1;

  function automatic model_t model_reset();
    model_t m;
    m.valid = 0; m.data = '0; m.last_wr = 1; m.streak = 0;
    m.n_rd = 0; m.n_wr = 0; m.n_stall = 0;
    return m;
  endfunction

  // Returns {wr_grant, rd_grant}.
  function automatic logic [1:0] model_grant(model_t m, int maxb, logic r, logic rq, logic wq, logic rd_y);
    bit give_wr;
    if (r || (m.valid && !rd_y) || (!rq && !wq)) return 2'b00;
    if (rq && !wq) return 2'b01;
    if (wq && !rq) return 2'b10;
    give_wr = (m.streak > 0 && m.streak < maxb) ? m.last_wr : !m.last_wr;
    return give_wr ? 2'b10 : 2'b01;
  endfunction

  function automatic model_t model_next(model_t m, int maxb, logic r, logic [1:0] g, logic rd_y,
                                        logic [W-1:0] rb, logic [W-1:0] wb);
    model_t n = m;
    if (r) return model_reset();
    if (m.valid && !rd_y) n.n_stall = (m.n_stall < 64'hFFFFFFFF) ? m.n_stall + 1 : m.n_stall;
    if (g != 2'b00) begin
      bit is_wr = g[1];
      n.data   = is_wr ? wb : rb;
      n.valid  = 1;
      n.streak = (is_wr == m.last_wr) ? ((m.streak + 1 > maxb) ? maxb : m.streak + 1) : 1;
      n.last_wr = is_wr;
      if (is_wr) n.n_wr = (m.n_wr < 64'hFFFFFFFF) ? m.n_wr + 1 : m.n_wr;
      else       n.n_rd = (m.n_rd < 64'hFFFFFFFF) ? m.n_rd + 1 : m.n_rd;
    end else if (m.valid && rd_y) begin
      n.valid = 0;
    end
    return n;
  endfunction

  typedef struct {
    logic         rst, rv, wv, rdy;
    logic         e_rg, e_wg, e_valid;
    logic [W-1:0] e_req;
  } vec_t;

  vec_t tbl[29];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; rv = 0; wv = 0; rdy = 1; rbus = '0; wbus = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; rv = 0; wv = 0; rdy = 1; rbus = '0; wbus = '0;

    // Rows: rst rv wv rdy | exp rd_grant wr_grant mem_req_valid mem_req. Buses are A000+row / B000+row.
    tbl[0]  = '{1,1,1,1, 0,0,0, 64'h0};
    tbl[1]  = '{0,1,0,1, 1,0,0, 64'h0};
    tbl[2]  = '{0,1,0,1, 1,0,1, 64'hA001};
    tbl[3]  = '{0,1,0,1, 1,0,1, 64'hA002};
    tbl[4]  = '{0,0,0,1, 0,0,1, 64'hA003};
    tbl[5]  = '{0,0,0,1, 0,0,0, 64'hA003};
    tbl[6]  = '{0,0,1,0, 0,1,0, 64'hA003};
    tbl[7]  = '{0,0,1,0, 0,0,1, 64'hB006};
    tbl[8]  = '{0,0,1,0, 0,0,1, 64'hB006};
    tbl[9]  = '{0,0,1,0, 0,0,1, 64'hB006};
    tbl[10] = '{0,0,1,0, 0,0,1, 64'hB006};
    tbl[11] = '{0,0,1,1, 0,1,1, 64'hB006};
    tbl[12] = '{0,0,0,1, 0,0,1, 64'hB00B};
    tbl[13] = '{0,0,0,1, 0,0,0, 64'hB00B};
    tbl[14] = '{0,1,0,1, 1,0,0, 64'hB00B};
    tbl[15] = '{0,1,0,1, 1,0,1, 64'hA00E};
    tbl[16] = '{0,1,0,1, 1,0,1, 64'hA00F};
    tbl[17] = '{0,1,0,1, 1,0,1, 64'hA010};
    tbl[18] = '{0,1,0,1, 1,0,1, 64'hA011};
    tbl[19] = '{0,0,0,1, 0,0,1, 64'hA012};
    tbl[20] = '{0,0,0,1, 0,0,0, 64'hA012};
    tbl[21] = '{0,1,1,1, 1,0,0, 64'hA012};
    tbl[22] = '{0,1,1,1, 1,0,1, 64'hA015};
    tbl[23] = '{0,1,1,1, 1,0,1, 64'hA016};
    tbl[24] = '{0,1,1,1, 0,1,1, 64'hA017};
    tbl[25] = '{0,1,1,1, 0,1,1, 64'hB018};
    tbl[26] = '{0,1,0,0, 0,0,1, 64'hB019};
    tbl[27] = '{1,1,0,0, 0,0,1, 64'hB019};
    tbl[28] = '{0,0,0,0, 0,0,0, 64'h0};

    do_reset();

    for (int r = 0; r < 29; r++) begin
      @(posedge clk); #1;
      rst = tbl[r].rst; rv = tbl[r].rv; wv = tbl[r].wv; rdy = tbl[r].rdy;
      rbus = 64'hA000 + W'(r); wbus = 64'hB000 + W'(r);
      @(negedge clk);
      check($sformatf("tbl%0d rd_grant", r), W'(rg8), W'(tbl[r].e_rg));
      check($sformatf("tbl%0d wr_grant", r), W'(wg8), W'(tbl[r].e_wg));
      check($sformatf("tbl%0d mem_req_valid", r), W'(mv8), W'(tbl[r].e_valid));
      check($sformatf("tbl%0d mem_req", r), mreq8, tbl[r].e_req);
    end
`ifdef DNN2AMI_ARB_STATS_EN
    check("stat_rd after reset", W'(s_rd8), '0);
    check("stat_wr after reset", W'(s_wr8), '0);
    check("stat_stall after reset", W'(s_st8), '0);
`endif

    // Both requesters saturated: 8/8 bursts on dut8, strict alternation on dut1.
    do_reset();
    begin
      logic [W-1:0] prev8, prev1;
      prev8 = '0; prev1 = '0;
      for (int c = 0; c < 20; c++) begin
        bit e8_rd, e1_rd;
        @(posedge clk); #1;
        rv = 1; wv = 1; rdy = 1;
        rbus = 64'hC000 + W'(c); wbus = 64'hD000 + W'(c);
        e8_rd = ((c / 8) % 2) == 0;
        e1_rd = (c % 2) == 0;
        @(negedge clk);
        check($sformatf("burst8 c%0d rd_grant", c), W'(rg8), W'(e8_rd));
        check($sformatf("burst8 c%0d wr_grant", c), W'(wg8), W'(!e8_rd));
        check($sformatf("alt1 c%0d rd_grant", c), W'(rg1), W'(e1_rd));
        check($sformatf("alt1 c%0d wr_grant", c), W'(wg1), W'(!e1_rd));
        if (c > 0) begin
          check($sformatf("burst8 c%0d mem_req", c), mreq8, prev8);
          check($sformatf("alt1 c%0d mem_req", c), mreq1, prev1);
          check($sformatf("alt1 c%0d mem_req_valid", c), W'(mv1), W'(1));
        end
        prev8 = e8_rd ? rbus : wbus;
        prev1 = e1_rd ? rbus : wbus;
      end
    end

    // Randomized traffic against the model on both instances.
    do_reset();
    m8 = model_reset();
    m1 = model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [1:0] g8, g1;
      @(posedge clk); #1;
      rst  = ($urandom_range(0, 63) == 0);
      rv   = $urandom_range(0, 3) != 0;
      wv   = $urandom_range(0, 3) != 0;
      rdy  = $urandom_range(0, 3) != 0;
      rbus = {$urandom, $urandom};
      wbus = {$urandom, $urandom};
      @(negedge clk);
      g8 = model_grant(m8, 8, rst, rv, wv, rdy);
      g1 = model_grant(m1, 1, rst, rv, wv, rdy);
      check("rand8 grants", W'({wg8, rg8}), W'(g8));
      check("rand8 mem_req_valid", W'(mv8), W'(m8.valid));
      check("rand8 mem_req", mreq8, m8.data);
      check("rand1 grants", W'({wg1, rg1}), W'(g1));
      check("rand1 mem_req_valid", W'(mv1), W'(m1.valid));
      check("rand1 mem_req", mreq1, m1.data);
`ifdef DNN2AMI_ARB_STATS_EN
      check("rand8 stat_rd", W'(s_rd8), W'(m8.n_rd));
      check("rand8 stat_wr", W'(s_wr8), W'(m8.n_wr));
      check("rand8 stat_stall", W'(s_st8), W'(m8.n_stall));
      check("rand1 stat_rd", W'(s_rd1), W'(m1.n_rd));
`endif
      m8 = model_next(m8, 8, rst, g8, rdy, rbus, wbus);
      m1 = model_next(m1, 1, rst, g1, rdy, rbus, wbus);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/dnn2ami_req_arbiter.md
Name: dnn2ami_req_arbiter

Overview:
- Shares the single AMI request port between the DNN2AMI read path and the DNN2AMI write path.
- Grants at most one requester per cycle, using round-robin with a bounded burst lock so a streaming write does not starve reads.
- Feeds the memory port through a one-entry registered output stage with a valid/ready handshake.
- Sits between the DNN2AMI RD/WR paths and the AMI memory-system request input.

Parameters:
- REQ_W, `AMI_REQUEST_BUS_WIDTH, width of one AMI request bus.
- MAX_BURST, 8, maximum consecutive grants to one requester while the other is waiting; legal range 1..255.
- CNT_W, $clog2(MAX_BURST+1), width of the burst counter; derived, not overridden.

Ports:
- clk  input  1  clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- rd_reqValid  input  1  read path has a request at its queue head.
- rd_reqOut  input  REQ_W  read path request bus.
- rd_reqOut_grant  output  1  read request accepted this cycle; upstream dequeues on rd_reqValid && rd_reqOut_grant.
- wr_reqValid  input  1  write path has a request at its queue head.
- wr_reqOut  input  REQ_W  write path request bus.
- wr_reqOut_grant  output  1  write request accepted this cycle.
- mem_req_valid  output  1  output register holds a request.
- mem_req  output  REQ_W  registered request to the memory system.
- mem_req_ready  input  1  memory system accepts mem_req this cycle.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - mem_req_valid=0, mem_req=0.
  - burst_cnt=0; last_grant=WR, so the first arbitration favours RD.
  - Grants are combinationally 0 while rst=1.
- Slot availability: slot_free = !mem_req_valid || mem_req_ready.
- Grants are combinational and never asserted unless slot_free.
  - A grant is never given to a requester with valid=0.
  - rd_reqOut_grant and wr_reqOut_grant are never both 1.
- Arbitration when slot_free:
  - Only one requester valid: grant it.
  - Both valid, last_grant=X, burst_cnt<MAX_BURST: grant X (lock).
  - Both valid, burst_cnt>=MAX_BURST: grant the other requester.
- Update on a grant to Y:
  - mem_req<=Y's bus; mem_req_valid<=1.
  - If Y==last_grant, burst_cnt<=burst_cnt+1, saturating at MAX_BURST; else burst_cnt<=1.
  - last_grant<=Y.
- Drain without a new grant: if mem_req_valid && mem_req_ready, then mem_req_valid<=0.
- Simultaneous drain and load: the register is overwritten in the same cycle and mem_req_valid stays 1, giving one request per cycle throughput.
- Stall (mem_req_valid && !mem_req_ready):
  - mem_req is held stable; no grants.
  - burst_cnt and last_grant are held.
- Idle cycles (no grant): last_grant and burst_cnt are held; the lock resumes when the same requester returns.
- Latency: a grant in cycle N gives mem_req_valid=1 in cycle N+1.
- MAX_BURST=1: strict alternation whenever both requesters are valid.
- Reset mid-operation: a request held in the output register is discarded. The RD/WR paths share rst and are cleared together; no replay.
- The request payload is passed through unmodified; the arbiter does not inspect AMIRequest fields.

Optional Feature:
- Macro: DNN2AMI_ARB_STATS_EN.
- Defined: adds three output ports, each a 32-bit saturating counter cleared by rst.
  - stat_rd_grants increments per RD grant.
  - stat_wr_grants increments per WR grant.
  - stat_stall_cycles increments each cycle mem_req_valid && !mem_req_ready.
  - Each counter holds at 32'hFFFFFFFF.
- Not defined: the stat ports and counters do not exist; arbitration is identical.

Test Plan:
- Reset, then RD-only valid for 3 cycles with mem_req_ready=1 -> grants in cycles 0,1,2; mem_req_valid=1 in cycles 1..3 carrying the RD buses in order; wr_reqOut_grant=0 throughout.
- Both valid continuously, MAX_BURST=8, ready=1 -> first grant RD (last_grant=WR at reset), 8 consecutive RD grants, then 8 WR grants, repeating; never two grants in one cycle.
- MAX_BURST=1, both valid, ready=1 -> grants alternate RD,WR,RD,WR; mem_req sequence matches.
- WR valid, mem_req_ready=0 for 4 cycles after the first load -> mem_req stable for 4 cycles, no further grants; on ready=1 the next WR is granted in the same cycle and mem_req_valid stays 1.
- RD burst at burst_cnt=5, RD drops for 2 idle cycles, then both valid -> RD granted 3 more times before the switch to WR.
- rst asserted while mem_req_valid=1 and stalled -> next cycle mem_req_valid=0, grants 0; with DNN2AMI_ARB_STATS_EN all stat counters read 0.
